// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the alu_mdu execute unit.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_XOR  = 5'h02;
  localparam logic [4:0] ALU_OR   = 5'h03;
  localparam logic [4:0] ALU_AND  = 5'h04;
  localparam logic [4:0] ALU_SLL  = 5'h05;
  localparam logic [4:0] ALU_SRL  = 5'h06;
  localparam logic [4:0] ALU_SRA  = 5'h07;
  localparam logic [4:0] ALU_SLT  = 5'h08;
  localparam logic [4:0] ALU_SLTU = 5'h09;

  localparam logic [4:0] MDU_MUL    = 5'h10;
  localparam logic [4:0] MDU_MULH   = 5'h11;
  localparam logic [4:0] MDU_MULHSU = 5'h12;
  localparam logic [4:0] MDU_MULHU  = 5'h13;
  localparam logic [4:0] MDU_DIV    = 5'h14;
  localparam logic [4:0] MDU_DIVU   = 5'h15;
  localparam logic [4:0] MDU_REM    = 5'h16;
  localparam logic [4:0] MDU_REMU   = 5'h17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_mdu(input logic [4:0] op);
    return op[4];
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Operand/result bus of the execute unit: issue side and writeback side.
interface alu_mdu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the producer holds valid and payload stable until then.
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        op;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   src2;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, op, rs1, src2, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag
  );

  modport slave (
    input  in_valid, op, rs1, src2, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one bit per step on magnitudes, signs fixed on output.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            start,
  input  logic            step,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(XLEN);

  // hi/lo hold product {hi,lo} for multiply, {remainder, dividend/quotient} for divide.
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, rneg_q, rneg_d;
  logic [4:0] op_q, op_d;

  logic a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, quo, rem;
  logic [XLEN:0] mul_sum, div_trial;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign a_signed = (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
                    (op == MDU_DIV) || (op == MDU_REM);
  assign b_signed = (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  assign a_neg = a_signed && a[XLEN-1];
  assign b_neg = b_signed && b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
  assign div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, m_q};

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    op_d   = op_q;
    if (clear) begin
      hi_d   = '0;
      lo_d   = '0;
      m_d    = '0;
      cnt_d  = '0;
      neg_d  = 1'b0;
      rneg_d = 1'b0;
      op_d   = '0;
    end else if (start) begin
      op_d   = op;
      cnt_d  = '0;
      hi_d   = '0;
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      lo_d   = op[2] ? a_mag : b_mag;
      m_d    = op[2] ? b_mag : a_mag;
    end else if (step && (cnt_q != CNT_END)) begin
      cnt_d = cnt_q + 1'b1;
      if (op_q[2]) begin
        // Restoring step: keep the trial remainder only when it did not borrow.
        if (!div_trial[XLEN]) begin
          hi_d = div_trial[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      op_q   <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      op_q   <= op_d;
    end
  end

  assign last     = (cnt_q == CNT_LAST);
  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo      = neg_q ? -lo_q : lo_q;
  assign rem      = rneg_q ? -hi_q : hi_q;

  always_comb begin
    res = rem;
    case (op_q)
      MDU_MUL:                          res = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  res = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                res = quo;
      default:                          res = rem;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// Registered RV32I ALU + iterative RV32M execute unit with valid/ready on both sides.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  alu_mdu_if.slave bus,
  output logic   busy,
  output state_e dbg_state
);
  localparam int SHAMT_W = $clog2(XLEN);

  state_e state_q, state_d;
  logic out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, tag_hold_q, tag_hold_d;

  logic accept, fire, mdu_op, div_op, signed_div, div_zero, div_ovf, special, iter_start;
  logic iter_last;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0] base_res, special_res, quick_res, iter_res;

  assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign fire         = out_valid_q && bus.out_ready;
  assign shamt        = bus.src2[SHAMT_W-1:0];

  always_comb begin
    base_res = '0;
    case (bus.op)
      ALU_ADD:  base_res = bus.rs1 + bus.src2;
      ALU_SUB:  base_res = bus.rs1 - bus.src2;
      ALU_XOR:  base_res = bus.rs1 ^ bus.src2;
      ALU_OR:   base_res = bus.rs1 | bus.src2;
      ALU_AND:  base_res = bus.rs1 & bus.src2;
      ALU_SLL:  base_res = bus.rs1 << shamt;
      ALU_SRL:  base_res = bus.rs1 >> shamt;
      ALU_SRA:  base_res = $signed(bus.rs1) >>> shamt;
      ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(bus.rs1) < $signed(bus.src2)};
      ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, bus.rs1 < bus.src2};
      default:  base_res = '0;
    endcase
  end

  // Codes 0x18-0x1F share op[4] with the M group but are unknown ops.
  assign mdu_op     = is_mdu(bus.op) && !bus.op[3];
  assign div_op     = mdu_op && bus.op[2];
  assign signed_div = (bus.op == MDU_DIV) || (bus.op == MDU_REM);
  assign div_zero   = div_op && (bus.src2 == '0);
  assign div_ovf    = div_op && signed_div && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (bus.src2 == '1);
  assign special    = div_zero || div_ovf;
  assign iter_start = accept && mdu_op && !special;

  // op[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    if (div_zero) special_res = bus.op[1] ? bus.rs1 : '1;
    else          special_res = bus.op[1] ? '0 : bus.rs1;
  end
  assign quick_res = mdu_op ? special_res : base_res;

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .start (iter_start),
    .step  (state_q == BUSY),
    .op    (bus.op),
    .a     (bus.rs1),
    .b     (bus.src2),
    .last  (iter_last),
    .res   (iter_res)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !fire;
    result_d    = result_q;
    out_tag_d   = out_tag_q;
    tag_hold_d  = tag_hold_q;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iter_start) begin
            state_d    = BUSY;
            tag_hold_d = bus.in_tag;
          end else if (accept) begin
            out_valid_d = 1'b1;
            result_d    = quick_res;
            out_tag_d   = bus.in_tag;
          end
        end
        BUSY: if (iter_last) state_d = DONE;
        DONE: begin
          if (!out_valid_q || bus.out_ready) begin
            out_valid_d = 1'b1;
            result_d    = iter_res;
            out_tag_d   = tag_hold_q;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
      tag_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_tag_q   <= out_tag_d;
      tag_hold_q  <= tag_hold_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_tag   = out_tag_q;
  assign busy          = (state_q == BUSY);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: base ops, multi-cycle M ops, special cases, hold, flush, reset.
module tb_alu_mdu;
  import alu_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   flush;
  logic   busy;
  state_e dbg_state;
  int     checks = 0;
  int     failures = 0;

  alu_mdu_if #(.XLEN(32), .TAG_W(5)) bus ();

  alu_mdu #(.XLEN(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Offer one op and wait (bounded) for the accepting edge; returns at edge+1.
  task automatic send(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t);
    bit done = 1'b0;
    bus.op = o; bus.rs1 = a; bus.src2 = b; bus.in_tag = t; bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      done = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_accept op=%h got in_ready=0 for 50 cycles, expected acceptance", o);
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.op = '0; bus.rs1 = '0; bus.src2 = '0; bus.in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++;
    if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got %h exp 0", bus.result); end
    checks++;
    if (bus.out_tag !== 5'h0) begin failures++; $display("FAIL reset_out_tag got %h exp 0", bus.out_tag); end
    checks++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      failures++; $display("FAIL reset_state got busy=%b state=%0d exp 0/IDLE", busy, dbg_state);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1'b1;
    bus.op = ALU_ADD; bus.rs1 = 32'h7FFF_FFFF; bus.src2 = 32'h1; bus.in_tag = 5'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h8000_0000 || bus.out_tag !== 5'd3) begin
      failures++;
      $display("FAIL b2b_add got v=%b res=%h tag=%0d exp 1/80000000/3", bus.out_valid, bus.result, bus.out_tag);
    end
    bus.op = ALU_SRA; bus.rs1 = 32'h8000_0000; bus.src2 = 32'h24; bus.in_tag = 5'd7;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got %b exp 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'hF800_0000 || bus.out_tag !== 5'd7) begin
      failures++;
      $display("FAIL b2b_sra got v=%b res=%h tag=%0d exp 1/f8000000/7", bus.out_valid, bus.result, bus.out_tag);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got v=%b exp 0", bus.out_valid); end
  endtask

  logic [4:0]  b_op [10] = '{ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA,
                             5'h0A, 5'h1B, ALU_SLT};
  logic [31:0] b_a  [10] = '{32'd5, 32'hF0F0_F0F0, 32'h0F00_0000, 32'hF0F0_F0F0, 32'h1,
                             32'h8000_0000, 32'h7FFF_FFF0, 32'd123, 32'd55, 32'hFFFF_FFFF};
  logic [31:0] b_b  [10] = '{32'd7, 32'hFF00_FF00, 32'h0000_00F0, 32'hFF00_FF00, 32'h21,
                             32'h1F, 32'h4, 32'd456, 32'd66, 32'h1};
  logic [31:0] b_exp[10] = '{32'hFFFF_FFFE, 32'h0FF0_0FF0, 32'h0F00_00F0, 32'hF000_F000, 32'h2,
                             32'h1, 32'h07FF_FFFF, 32'h0, 32'h0, 32'h1};

  task automatic test_base_ops;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(b_op[i], b_a[i], b_b[i], 5'(i));
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== b_exp[i] || busy !== 1'b0) begin
        failures++;
        $display("FAIL base_op%0d op=%h got v=%b res=%h busy=%b exp 1/%h/0",
                 i, b_op[i], bus.out_valid, bus.result, busy, b_exp[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  logic [4:0]  m_op [6] = '{MDU_MULH, MDU_MULHU, MDU_MUL, MDU_MULHSU, MDU_DIVU, MDU_REMU};
  logic [31:0] m_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h2, 32'd100, 32'd100};
  logic [31:0] m_b  [6] = '{32'h2, 32'h2, 32'd5, 32'hFFFF_FFFF, 32'd7, 32'd7};
  logic [31:0] m_exp[6] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF1, 32'h1, 32'd14, 32'd2};

  task automatic test_mul;
    int cyc;
    int bc;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(m_op[i], m_a[i], m_b[i], 5'(10 + i));
      bc = busy ? 1 : 0;
      cyc = 0;
      while (!bus.out_valid && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
        if (busy) bc++;
      end
      checks++;
      if (cyc != 33) begin failures++; $display("FAIL mdu%0d_latency got %0d exp 33", i, cyc); end
      checks++;
      if (bc != 32) begin failures++; $display("FAIL mdu%0d_busy_cycles got %0d exp 32", i, bc); end
      checks++;
      if (bus.result !== m_exp[i] || bus.out_tag !== 5'(10 + i)) begin
        failures++;
        $display("FAIL mdu%0d_result op=%h got %h tag=%0d exp %h tag=%0d",
                 i, m_op[i], bus.result, bus.out_tag, m_exp[i], 10 + i);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mdu%0d_fire got v=%b exp 0", i, bus.out_valid); end
    end
  endtask

  logic [4:0]  s_op [5] = '{MDU_DIV, MDU_REMU, MDU_DIV, MDU_REM, MDU_DIVU};
  logic [31:0] s_a  [5] = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd7};
  logic [31:0] s_b  [5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
  logic [31:0] s_exp[5] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};

  task automatic test_div_special;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(s_op[i], s_a[i], s_b[i], 5'(20 + i));
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== s_exp[i] || busy !== 1'b0) begin
        failures++;
        $display("FAIL special%0d op=%h got v=%b res=%h busy=%b exp 1/%h/0",
                 i, s_op[i], bus.out_valid, bus.result, busy, s_exp[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold;
    int cyc;
    bus.out_ready = 1'b0;
    send(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9);
    wait_out(cyc);
    checks++;
    if (cyc != 33 || bus.result !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL hold_div got lat=%0d res=%h exp 33/fffffffd", cyc, bus.result);
    end
    bus.op = ALU_ADD; bus.rs1 = 32'd1; bus.src2 = 32'd1; bus.in_tag = 5'd1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFF_FFFD || bus.out_tag !== 5'd9 ||
          bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got v=%b res=%h tag=%0d rdy=%b exp 1/fffffffd/9/0",
                 i, bus.out_valid, bus.result, bus.out_tag, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_fire got v=%b exp 0", bus.out_valid); end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_single_fire got v=%b exp 0", bus.out_valid); end
    send(MDU_REM, 32'hFFFF_FFF9, 32'd2, 5'd11);
    wait_out(cyc);
    checks++;
    if (cyc != 33 || bus.result !== 32'hFFFF_FFFF || bus.out_tag !== 5'd11) begin
      failures++;
      $display("FAIL hold_rem got lat=%0d res=%h tag=%0d exp 33/ffffffff/11", cyc, bus.result, bus.out_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    int seen;
    bus.out_ready = 1'b1;
    send(MDU_DIVU, 32'd1000, 32'd3, 5'd4);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    bus.op = ALU_ADD; bus.rs1 = 32'd9; bus.src2 = 32'd9; bus.in_tag = 5'd1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || dbg_state !== IDLE || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy got busy=%b state=%0d v=%b exp 0/IDLE/0", busy, dbg_state, bus.out_valid);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL flush_no_result got %0d valid cycles exp 0", seen); end
    flush = 1'b1; bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_accept got v=%b exp 0", bus.out_valid); end
    send(ALU_ADD, 32'd2, 32'd3, 5'd6);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd5 || bus.out_tag !== 5'd6) begin
      failures++;
      $display("FAIL flush_add got v=%b res=%h tag=%0d exp 1/5/6", bus.out_valid, bus.result, bus.out_tag);
    end
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b1;
    send(MDU_MUL, 32'd12345, 32'd678, 5'd2);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.out_tag !== 5'h0 ||
        dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_mid got busy=%b v=%b res=%h tag=%0d state=%0d exp all 0",
               busy, bus.out_valid, bus.result, bus.out_tag, dbg_state);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd12);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd1) begin
      failures++; $display("FAIL sltu got v=%b res=%h exp 1/1", bus.out_valid, bus.result);
    end
    send(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 5'd13);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd0) begin
      failures++; $display("FAIL slt got v=%b res=%h exp 1/0", bus.out_valid, bus.result);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_base_ops();
    test_mul();
    test_div_special();
    test_hold();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the core combinational ALU.
- Registered XLEN-wide execute unit: all RV32I ALU operations plus the RV32M multiply/divide family.
- Valid/ready handshake on both input and output, so the execute stage can stall on multi-cycle ops.
- Sits in EX between operand muxing and writeback. A tag (destination register index) travels with each op.

Parameters:
- XLEN, 32, datapath width; must be a power of two, at least 8.
- TAG_W, 5, width of the pass-through tag.
- SHAMT_W, $clog2(XLEN), derived localparam (not overridable); number of shift-amount bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of any in-flight or pending op.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the op this cycle.
- op  in  5  operation code (see package).
- rs1  in  XLEN  operand A.
- src2  in  XLEN  operand B (register or immediate).
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  operation result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  high while in state BUSY.

Behaviour:
- Reset: asynchronous, rst_n low. State IDLE; out_valid=0, result=0, out_tag=0, busy=0, all iteration registers cleared.
- in_ready = (state==IDLE) && (!out_valid || out_ready). An op is accepted on in_valid && in_ready.
- Base ops, codes 0x00–0x09: ADD SUB XOR OR AND SLL SRL SRA SLT SLTU.
  - Result is registered on acceptance; out_valid rises the next cycle (latency 1).
  - Shifts use only src2[SHAMT_W-1:0].
  - SLT/SLTU return 1 or 0, zero-extended.
- Base back-to-back: with out_ready held high, one base op per cycle.
- Unknown op codes: result 0, latency 1, no error flag.
- M ops, codes 0x10–0x17: MUL MULH MULHSU MULHU DIV DIVU REM REMU.
  - Enter BUSY and iterate one bit per cycle for XLEN cycles:
    - multiply: shift-add on a 2*XLEN product, operands made magnitude-only with the final sign fixed;
    - divide: restoring divide on magnitudes, quotient/remainder signs fixed at the end.
  - Go to DONE; out_valid rises after the last iteration. Latency XLEN+1 cycles from acceptance.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Special cases, latency 1, no iteration:
  - divide by zero: DIV/DIVU return all-ones; REM/REMU return rs1.
  - signed overflow, rs1 = -2^(XLEN-1) and src2 = -1: DIV returns rs1; REM returns 0.
- State machine:
  - IDLE → BUSY on accepting an M op (non-special).
  - BUSY → DONE when the iteration counter reaches XLEN-1.
  - DONE → IDLE once the result is loaded into the output register.
  - Base ops never leave IDLE.
- Output hold: result, out_tag and out_valid stay stable while out_valid && !out_ready. Fire = out_valid && out_ready; out_valid drops after fire unless a new base op is accepted in the same cycle.
- Flush (priority over everything except reset):
  - next cycle: state IDLE, out_valid=0, busy=0;
  - an op offered in the same cycle as flush is not accepted (in_ready forced 0 when flush is high).
- Reset mid-iteration: abandons the op immediately. No partial result is ever presented.
- Counter width is SHAMT_W+1; it is not allowed to wrap past XLEN.

Decomposition:
- Package alu_pkg holds the op codes as localparams:
  - ALU_ADD..ALU_SLTU = 5'h00..5'h09;
  - MDU_MUL..MDU_REMU = 5'h10..5'h17;
  - the FSM state encodings IDLE/BUSY/DONE;
  - helper function is_mdu(op) = op[4].
- One natural sub-module: mdu_iter, the iterative multiply/divide datapath with start/done.
  - It is owned by the top FSM.
  - The top keeps the base ALU logic, the special cases and the output register.

Test Plan:
- ADD 0x7FFFFFFF + 1, then SRA 0x80000000 by 4, with src2=0x24 (only the low 5 bits count) → 0x80000000 after 1 cycle, then 0xF8000000 on consecutive cycles; out_tag echoes 3 then 7.
- MULH rs1=0xFFFFFFFF(-1), src2=2 → 0xFFFFFFFF. MULHU with the same operands → 0x00000001. MUL -3×5 → 0xFFFFFFF1. out_valid exactly 33 cycles after acceptance; busy high 32 cycles.
- DIV 7/0 → 0xFFFFFFFF; REMU 7/0 → 7; DIV 0x80000000/-1 → 0x80000000; REM of the same → 0. All at latency 1.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF. Hold out_ready low 5 cycles: result stable, in_ready=0; then release and check a single fire.
- Start DIVU, assert flush at iteration 10 → next cycle IDLE, no out_valid. A following ADD 2+3 → 5.
- Start MUL, drop rst_n asynchronously mid-cycle → all outputs 0 immediately. After release, SLTU 1 vs 0xFFFFFFFF → 1 and SLT of the same → 0.
